// File: rtl/aes_key_server.sv
`default_nettype none
// aes_key_server: multi-slot AES key-schedule server built around the key_top expansion core.
// Optional feature macro KEY_SERVER_LOAD_ACK_EN: a completed LOAD emits one acknowledge beat.

// key_top: iterative AES key expansion, NPAR schedule words per cycle, 2048-bit zero-padded output.
module key_top #(
  parameter int OPERATION = 0,
  parameter int NPAR      = 4,
  parameter int KEY_WIDTH = 256
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 stall,
  input  logic                 keyVal_in,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic                 keyVal_out,
  output logic [2047:0]        key_out
);
  localparam int NK = KEY_WIDTH / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [31:0] w [64];
  logic [31:0] w_nxt [64];
  logic [6:0]  idx, idx_nxt;
  logic [3:0]  pos, pos_nxt;
  logic [7:0]  rc, rc_nxt;
  logic [31:0] temp;
  logic [5:0]  k_prev, k_back;
  logic        busy, done;

  // pos tracks the word position within the NK-word key period, so no modulo is needed
  always_comb begin
    w_nxt   = w;
    idx_nxt = idx;
    pos_nxt = pos;
    rc_nxt  = rc;
    temp    = '0;
    k_prev  = '0;
    k_back  = '0;
    for (int j = 0; j < NPAR; j++) begin
      if (int'(idx_nxt) < NW) begin
        k_prev = 6'(idx_nxt - 7'd1);
        k_back = 6'(idx_nxt - 7'(NK));
        temp   = w_nxt[k_prev];
        if (pos_nxt == 4'd0) begin
          temp   = sub_word({temp[23:0], temp[31:24]}) ^ {rc_nxt, 24'h0};
          rc_nxt = xtime(rc_nxt);
        end else if (NK == 8 && pos_nxt == 4'd4) begin
          temp = sub_word(temp);
        end
        w_nxt[6'(idx_nxt)] = w_nxt[k_back] ^ temp;
        idx_nxt = idx_nxt + 7'd1;
        pos_nxt = (pos_nxt == 4'(NK - 1)) ? 4'd0 : pos_nxt + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (keyVal_in) begin
        busy <= 1'b1;
      end else if (busy && !stall && int'(idx_nxt) >= NW) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (keyVal_in) begin
      for (int i = 0; i < NK; i++) w[i] <= key_in[KEY_WIDTH-1-32*i -: 32];
      for (int i = NK; i < 64; i++) w[i] <= 32'h0;
      idx <= 7'(NK);
      pos <= 4'd0;
      rc  <= 8'h01;
    end else if (busy && !stall) begin
      w   <= w_nxt;
      idx <= idx_nxt;
      pos <= pos_nxt;
      rc  <= rc_nxt;
    end
  end

  // Decryption schedules list the round keys last-round first
  always_comb begin
    key_out = '0;
    for (int r = 0; r <= NR; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (OPERATION == 0) key_out[128*r+32*c +: 32] = w[4*r+c];
        else                key_out[128*(NR-r)+32*c +: 32] = w[4*r+c];
      end
    end
  end

  assign keyVal_out = done;
endmodule

module aes_key_server #(
  parameter int OPERATION = 0,
  parameter int N_PIPES   = 4,
  parameter int KEY_WIDTH = 256,
  parameter int N_SLOTS   = 4,
  parameter int OUT_WIDTH = 1024
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ivalid,
  output logic                 oready,
  input  logic [255:0]         datain,
  input  logic [7:0]           flagin,
  output logic                 ovalid,
  input  logic                 iready,
  output logic [OUT_WIDTH-1:0] dataout,
  output logic [7:0]           obeat,
  output logic [3:0]           oslot,
  output logic                 olast,
  output logic                 oerr
);
  localparam int NBEATS = 2048 / OUT_WIDTH;
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [3:0] OP_LOAD       = 4'd1;
  localparam logic [3:0] OP_READ_ALL   = 4'd2;
  localparam logic [3:0] OP_READ_BEAT  = 4'd3;
  localparam logic [3:0] OP_INVALIDATE = 4'd4;

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM, ERR} state_t;
  state_t state, state_nxt;

  logic [2047:0]        sched [N_SLOTS];
  logic [N_SLOTS-1:0]   slot_valid;
  logic [3:0]           cur_slot;
  logic [7:0]           cur_beat, last_beat;
  logic                 ack;
  logic                 key_start, key_done;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [2047:0]        key_sched;
  logic [2047:0]        sel_sched;
  logic [OUT_WIDTH-1:0] beats [NBEATS];
  logic [3:0]           op, req_slot;
  logic [7:0]           req_beat;
  logic                 slot_ok, beat_ok, req_valid;

  assign op       = flagin[7:4];
  assign req_slot = flagin[3:0];
  assign req_beat = datain[7:0];
  assign slot_ok  = int'(req_slot) < N_SLOTS;
  assign beat_ok  = int'(req_beat) < NBEATS;

  always_comb begin
    req_valid = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (req_slot == 4'(i)) req_valid = slot_valid[i];
    end
  end

  key_top #(
    .OPERATION (OPERATION),
    .NPAR      (N_PIPES),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_key_top (
    .clock      (clock),
    .resetn     (resetn),
    .stall      (1'b0),
    .keyVal_in  (key_start),
    .key_in     (key_reg),
    .keyVal_out (key_done),
    .key_out    (key_sched)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oready    = 1'b0;
    unique case (state)
      IDLE: begin
        oready = 1'b1;
        if (ivalid) begin
          case (op)
            OP_LOAD:       state_nxt = slot_ok ? EXPAND : ERR;
            OP_READ_ALL:   state_nxt = req_valid ? STREAM : ERR;
            OP_READ_BEAT:  state_nxt = (req_valid && beat_ok) ? STREAM : ERR;
            OP_INVALIDATE: state_nxt = IDLE;
            default:       state_nxt = ERR;
          endcase
        end
      end
      EXPAND: begin
        if (key_done) begin
`ifdef KEY_SERVER_LOAD_ACK_EN
          state_nxt = STREAM;
`else
          state_nxt = IDLE;
`endif
        end
      end
      STREAM:  if (iready && olast) state_nxt = IDLE;
      ERR:     if (iready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      slot_valid <= '0;
      cur_slot   <= 4'd0;
      cur_beat   <= 8'd0;
      last_beat  <= 8'd0;
      ack        <= 1'b0;
      key_start  <= 1'b0;
    end else begin
      key_start <= 1'b0;
      if (state == IDLE && ivalid) begin
        cur_slot  <= req_slot;
        ack       <= 1'b0;
        cur_beat  <= (op == OP_READ_BEAT) ? req_beat : 8'd0;
        last_beat <= (op == OP_READ_BEAT) ? req_beat : 8'(NBEATS - 1);
        if (op == OP_LOAD && slot_ok) key_start <= 1'b1;
        if (op == OP_INVALIDATE) begin
          for (int i = 0; i < N_SLOTS; i++) begin
            if (req_slot == 4'(i)) slot_valid[i] <= 1'b0;
          end
        end
      end
      if (state == EXPAND && key_done) begin
        for (int i = 0; i < N_SLOTS; i++) begin
          if (cur_slot == 4'(i)) slot_valid[i] <= 1'b1;
        end
        cur_beat <= 8'd0;
`ifdef KEY_SERVER_LOAD_ACK_EN
        ack <= 1'b1;
`endif
      end
      if (state == STREAM && iready && !olast) cur_beat <= cur_beat + 8'd1;
    end
  end

  // Schedule storage carries no reset: slot_valid alone decides readability
  always_ff @(posedge clock) begin
    if (state == IDLE && ivalid && op == OP_LOAD) key_reg <= datain[KEY_WIDTH-1:0];
    if (state == EXPAND && key_done) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (cur_slot == 4'(i)) sched[i] <= key_sched;
      end
    end
  end

  assign sel_sched = sched[cur_slot[SW-1:0]];

  always_comb begin
    for (int b = 0; b < NBEATS; b++) beats[b] = sel_sched[b*OUT_WIDTH +: OUT_WIDTH];
  end

  assign ovalid  = (state == STREAM) || (state == ERR);
  assign oerr    = (state == ERR);
  assign olast   = (state == ERR) || (state == STREAM && (ack || cur_beat == last_beat));
  assign obeat   = cur_beat;
  assign oslot   = cur_slot;
  assign dataout = (state == STREAM && !ack) ? beats[cur_beat[BW-1:0]] : '0;
endmodule
`default_nettype wire

// File: tb/tb_aes_key_server.sv
`default_nettype none
// tb_aes_key_server: directed scoreboard bench with an independent GF(2^8) AES key-expansion model.
module tb_aes_key_server;
  localparam int OW = 1024;
  localparam int NB = 2048 / OW;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          ivalid = 1'b0;
  logic          iready = 1'b1;
  logic [255:0]  datain = '0;
  logic [7:0]    flagin = '0;
  logic          oready, ovalid, olast, oerr;
  logic [OW-1:0] dataout;
  logic [7:0]    obeat;
  logic [3:0]    oslot;

  aes_key_server #(
    .OPERATION (0), .N_PIPES (4), .KEY_WIDTH (256), .N_SLOTS (4), .OUT_WIDTH (OW)
  ) dut (
    .clock (clock), .resetn (resetn), .ivalid (ivalid), .oready (oready),
    .datain (datain), .flagin (flagin), .ovalid (ovalid), .iready (iready),
    .dataout (dataout), .obeat (obeat), .oslot (oslot), .olast (olast), .oerr (oerr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [7:0]    beat;
    logic [3:0]    slot;
    logic          last;
    logic          err;
  } exp_t;

  exp_t          sbq[$];
  exp_t          cur_e;
  int            errors = 0;
  int            checks = 0;
  logic [7:0]    sbox_tab [256];
  logic [2047:0] msched [4];
  logic [3:0]    mvalid = '0;
  logic          stall_prev = 1'b0;
  logic [2047:0] held = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_wide(input string tag, input logic [2047:0] obs, input logic [2047:0] expv);
    int k;
    k = 0;
    checks++;
    assert (obs === expv) else begin
      errors++;
      for (int i = 31; i >= 0; i--) if (obs[64*i +: 64] !== expv[64*i +: 64]) k = i;
      $error("FAIL %s: word %0d got %h expected %h", tag, k, obs[64*k +: 64], expv[64*k +: 64]);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map
  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv, b;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    b = (x == 8'h00) ? 8'h00 : inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  function automatic logic [2047:0] model_sched(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [2047:0] s;
    rc = 8'h01;
    s  = '0;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = m_sub(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      if (stall_prev) check_wide("stall_hold", {1010'd0, dataout, obeat, oslot, olast, oerr, ovalid}, held);
      if (ovalid && iready) begin
        if (sbq.size() == 0) begin
          check("unexpected_beat", 64'(ovalid), 64'd0);
        end else begin
          cur_e = sbq.pop_front();
          check_wide("beat_data", 2048'(dataout), 2048'(cur_e.data));
          if (!cur_e.err) check("beat_index", 64'(obeat), 64'(cur_e.beat));
          check("beat_slot", 64'(oslot), 64'(cur_e.slot));
          check("beat_last", 64'(olast), 64'(cur_e.last));
          check("beat_err", 64'(oerr), 64'(cur_e.err));
        end
      end
      stall_prev = ovalid && !iready;
      held = {1010'd0, dataout, obeat, oslot, olast, oerr, ovalid};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] slot, input logic [255:0] d);
    bit done;
    done = 1'b0;
    flagin = {op, slot};
    datain = d;
    ivalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (oready) done = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    if (!done) check("accept_timeout", 64'(oready), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      if (oready) ok = 1'b1;
    end
    if (!ok) check(tag, 64'(oready), 64'd1);
    tick();
  endtask

  task automatic push_err(input logic [3:0] slot);
    sbq.push_back('{data: '0, beat: 8'd0, slot: slot, last: 1'b1, err: 1'b1});
  endtask

  task automatic load(input logic [3:0] slot, input logic [255:0] key);
`ifdef KEY_SERVER_LOAD_ACK_EN
    sbq.push_back('{data: '0, beat: 8'd0, slot: slot, last: 1'b1, err: 1'b0});
`endif
    send(4'd1, slot, key);
    check("load_busy", 64'(oready), 64'd0);
    msched[slot[1:0]] = model_sched(key);
    mvalid[slot[1:0]] = 1'b1;
    wait_idle("load_timeout");
  endtask

  task automatic read_all(input logic [3:0] slot);
    if (slot < 4 && mvalid[slot[1:0]]) begin
      for (int b = 0; b < NB; b++)
        sbq.push_back('{data: msched[slot[1:0]][b*OW +: OW], beat: 8'(b), slot: slot,
                        last: (b == NB - 1), err: 1'b0});
    end else begin
      push_err(slot);
    end
    send(4'd2, slot, '0);
    check("read_ovalid", 64'(ovalid), 64'd1);
    wait_idle("read_timeout");
  endtask

  localparam logic [255:0] K0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KA = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KB = 256'hfedcba98765432100123456789abcdefdeadbeefcafef00d0badc0de12345678;

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = calc_sbox(8'(i));

    repeat (3) tick();
    resetn = 1'b1;
    check("rst_oready", 64'(oready), 64'd1);
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_olast", 64'(olast), 64'd0);
    check("rst_oerr", 64'(oerr), 64'd0);
    check_wide("rst_dataout", 2048'(dataout), '0);
    check("rst_obeat", 64'(obeat), 64'd0);
    check("rst_oslot", 64'(oslot), 64'd0);
    tick();

    load(4'd0, K0);
    read_all(4'd0);

    // single beat under toggling backpressure
    sbq.push_back('{data: msched[0][2047:1024], beat: 8'd1, slot: 4'd0, last: 1'b1, err: 1'b0});
    iready = 1'b0;
    send(4'd3, 4'd0, 256'd1);
    check("rb_ovalid", 64'(ovalid), 64'd1);
    for (int i = 0; i < 20 && !oready; i++) begin
      tick();
      iready = ~iready;
    end
    if (!oready) check("rb_timeout", 64'(oready), 64'd1);
    iready = 1'b1;
    tick();

    read_all(4'd2);
    read_all(4'd5);
    push_err(4'd0);
    send(4'd7, 4'd0, '0);
    check("badop_ovalid", 64'(ovalid), 64'd1);
    wait_idle("badop_timeout");
    push_err(4'd0);
    send(4'd3, 4'd0, 256'd2);
    wait_idle("badbeat_timeout");

    load(4'd1, KA);
    load(4'd1, KB);
    send(4'd4, 4'd0, '0);
    mvalid[0] = 1'b0;
    check("inval_ovalid", 64'(ovalid), 64'd0);
    check("inval_oready", 64'(oready), 64'd1);
    send(4'd4, 4'd9, '0);
    check("inval_oob_oready", 64'(oready), 64'd1);
    read_all(4'd1);
    read_all(4'd0);

    // reset lands while the second beat of a READ_ALL is on the bus
    sbq.push_back('{data: msched[1][OW-1:0], beat: 8'd0, slot: 4'd1, last: 1'b0, err: 1'b0});
    send(4'd2, 4'd1, '0);
    tick();
    resetn = 1'b0;
    tick();
    check("midrst_ovalid", 64'(ovalid), 64'd0);
    check("midrst_oready", 64'(oready), 64'd1);
    check("midrst_pending", 64'(sbq.size()), 64'd0);
    resetn = 1'b1;
    mvalid = '0;
    tick();
    read_all(4'd1);

`ifdef KEY_SERVER_LOAD_ACK_EN
    sbq.push_back('{data: '0, beat: 8'd0, slot: 4'd3, last: 1'b1, err: 1'b0});
    iready = 1'b0;
    send(4'd1, 4'd3, KA);
    for (int i = 0; i < 100 && !ovalid; i++) tick();
    check("ack_ovalid", 64'(ovalid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ack_hold_oready", 64'(oready), 64'd0);
    end
    iready = 1'b1;
    msched[3] = model_sched(KA);
    mvalid[3] = 1'b1;
    wait_idle("ack_timeout");
    read_all(4'd3);
`endif

    repeat (2) tick();
    check("queue_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
